// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer: parallel-in/serial-out framer feeding a serial
// sequence detector. One-word holding register in front of a shift engine.
// Frames stream back-to-back with no idle bit between them.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// Once in_valid is raised, the upstream keeps in_valid and in_data stable
// until that edge. in_ready never depends on in_valid.
module piso_frame_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             busy,
   output logic [CNT_W-1:0] frames_sent
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] frames_q, frames_d;

   logic             last_bit;
   logic             load_fire;
   logic             accept;
   logic [WIDTH-1:0] shifted;

   // Handshake and engine-control decode from the current registered state.
   always_comb begin
      last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
      load_fire = shift_en && hold_full_q && ((state_q == IDLE) || last_bit);
      in_ready  = reset && (!hold_full_q || load_fire);
      accept    = in_valid && in_ready;
      if (LSB_FIRST) begin
         shifted = {1'b0, shift_q[WIDTH-1:1]};
      end else begin
         shifted = {shift_q[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state: holding register fill/drain and the enabled shift engine.
   always_comb begin
      state_d     = state_q;
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      frames_d    = frames_q;

      // A same-edge accept refills the register that load_fire is draining.
      if (accept) begin
         hold_d      = in_data;
         hold_full_d = 1'b1;
      end else if (load_fire) begin
         hold_full_d = 1'b0;
      end

      if (shift_en) begin
         if (last_bit) begin
            frames_d = frames_q + CNT_W'(1);
         end
         if (load_fire) begin
            shift_d   = hold_q;
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end else if (last_bit) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
         end else if (state_q == SHIFT) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + BW'(1);
         end
      end
   end

   // State register; reset aborts any frame and drops the held word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         frames_q    <= '0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         frames_q    <= frames_d;
      end
   end

   // Outputs decoded only from registered state, so reset clears them at once.
   always_comb begin
      serial_valid = (state_q == SHIFT);
      frame_start  = (state_q == SHIFT) && (bit_cnt_q == '0);
      busy         = (state_q == SHIFT) || hold_full_q;
      frames_sent  = frames_q;
      if (state_q == SHIFT) begin
         serial_out = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
      end else begin
         serial_out = 1'b0;
      end
   end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: an LSB-first and an MSB-first instance
// share one stimulus stream; a word/bit-index model predicts every output.
module tb_piso_frame_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       shift_en = 1'b1;

   logic       rdy0, so0, sv0, fs0, busy0;
   logic       rdy1, so1, sv1, fs1, busy1;
   logic [7:0] fr0, fr1;

   int total = 0;
   int bad   = 0;

   // clock / reset block
   always #5 clk = ~clk;

   piso_frame_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .CNT_W(8)) dut_lsb (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .shift_en(shift_en), .serial_out(so0),
      .serial_valid(sv0), .frame_start(fs0), .busy(busy0), .frames_sent(fr0)
   );

   piso_frame_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .CNT_W(8)) dut_msb (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .shift_en(shift_en), .serial_out(so1),
      .serial_valid(sv1), .frame_start(fs1), .busy(busy1), .frames_sent(fr1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A frame is "word m_word, currently showing bit position m_idx".
   logic       m_hf;
   logic [7:0] m_hw;
   logic       m_act;
   logic [7:0] m_word;
   int         m_idx;
   logic [7:0] m_frames;
   logic       m_lf, m_rdy;

   assign m_lf  = shift_en && m_hf && (!m_act || m_idx == 7);
   assign m_rdy = reset && (!m_hf || m_lf);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hf <= 1'b0; m_hw <= 8'h00; m_act <= 1'b0;
         m_word <= 8'h00; m_idx <= 0; m_frames <= 8'h00;
      end else begin
         if (in_valid && m_rdy) begin
            m_hw <= in_data;
            m_hf <= 1'b1;
         end else if (m_lf) begin
            m_hf <= 1'b0;
         end
         if (shift_en) begin
            if (m_act && m_idx == 7) m_frames <= m_frames + 8'd1;
            if (m_lf) begin
               m_word <= m_hw; m_idx <= 0; m_act <= 1'b1;
            end else if (m_act && m_idx == 7) begin
               m_act <= 1'b0;
            end else if (m_act) begin
               m_idx <= m_idx + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("in_ready_lsb", rdy0, m_rdy);
      chk("in_ready_msb", rdy1, m_rdy);
      chk("serial_valid_lsb", sv0, m_act);
      chk("serial_valid_msb", sv1, m_act);
      chk("serial_out_lsb", so0, m_act ? m_word[m_idx] : 1'b0);
      chk("serial_out_msb", so1, m_act ? m_word[7 - m_idx] : 1'b0);
      chk("frame_start_lsb", fs0, m_act && m_idx == 0);
      chk("frame_start_msb", fs1, m_act && m_idx == 0);
      chk("busy_lsb", busy0, m_act || m_hf);
      chk("busy_msb", busy1, m_act || m_hf);
      chk("frames_lsb", fr0, m_frames);
      chk("frames_msb", fr1, m_frames);
   end

   // ---------------- serial stream capture ----------------
   logic cap0[$];
   logic cap1[$];
   int   fsp0[$];

   always @(negedge clk) begin
      if (reset) begin
         if (sv0) begin
            cap0.push_back(so0);
            if (fs0) fsp0.push_back(cap0.size() - 1);
         end
         if (sv1) cap1.push_back(so1);
      end
   end

   // First captured bit ends up in the most significant position.
   function automatic logic [31:0] pack(input int sel);
      logic [31:0] acc;
      acc = 32'h0;
      if (sel == 0) foreach (cap0[i]) acc = {acc[30:0], cap0[i]};
      else          foreach (cap1[i]) acc = {acc[30:0], cap1[i]};
      return acc;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_caps();
      cap0.delete(); cap1.delete(); fsp0.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      clear_caps();
   endtask

   // Called and returns #1 after a rising edge; holds the word until accepted.
   task automatic send_word(input logic [7:0] w);
      logic got;
      got = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = rdy0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      logic idle;
      idle = 1'b0;
      for (int i = 0; i < 300 && !idle; i++) begin
         @(negedge clk);
         idle = !busy0 && !busy1;
      end
      @(posedge clk);
      #1;
      if (!idle) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      do_reset();

      // single frame C5
      send_word(8'hC5);
      wait_idle();
      chk("single_len", cap0.size(), 8);
      chk("single_bits_lsb", pack(0), 32'hA3);
      chk("single_bits_msb", pack(1), 32'hC5);
      chk("single_fs_count", fsp0.size(), 1);
      chk("single_frames", fr0, 8'd1);
      chk("single_busy", busy0, 1'b0);

      // back-to-back C5 then 3A
      do_reset();
      send_word(8'hC5);
      step(3);
      send_word(8'h3A);
      wait_idle();
      chk("b2b_len", cap0.size(), 16);
      chk("b2b_bits_lsb", pack(0), 32'hA35C);
      chk("b2b_bits_msb", pack(1), 32'hC53A);
      chk("b2b_fs_count", fsp0.size(), 2);
      if (fsp0.size() == 2) chk("b2b_fs_second", fsp0[1], 8);
      chk("b2b_frames", fr0, 8'd2);

      // backpressure: three words offered continuously
      do_reset();
      send_word(8'hC5);
      send_word(8'h3A);
      send_word(8'h96);
      wait_idle();
      chk("bp_len", cap0.size(), 24);
      chk("bp_bits_lsb", pack(0), 32'hA35C69);
      chk("bp_bits_msb", pack(1), 32'hC53A96);
      chk("bp_frames", fr0, 8'd3);

      // stall for 3 edges after bit 2 is shown
      do_reset();
      send_word(8'hC5);
      step(3);
      shift_en = 1'b0;
      step(3);
      shift_en = 1'b1;
      wait_idle();
      chk("stall_len", cap0.size(), 11);
      chk("stall_bits_lsb", pack(0), 32'b10111100011);
      chk("stall_bits_msb", pack(1), 32'b11000000101);
      chk("stall_frames", fr0, 8'd1);

      // reset mid-frame with a word held
      do_reset();
      send_word(8'hC5);
      send_word(8'h3A);
      step(4);
      chk("pre_reset_busy", busy0, 1'b1);
      reset = 1'b0;
      #1;
      chk("arst_serial_out", {so0, so1}, 2'b00);
      chk("arst_serial_valid", {sv0, sv1}, 2'b00);
      chk("arst_frame_start", {fs0, fs1}, 2'b00);
      chk("arst_busy", {busy0, busy1}, 2'b00);
      chk("arst_in_ready", {rdy0, rdy1}, 2'b00);
      chk("arst_frames", fr0, 8'd0);
      step(2);
      reset = 1'b1;
      clear_caps();
      step(30);
      chk("post_reset_no_bits", cap0.size(), 0);
      chk("post_reset_frames", fr0, 8'd0);

      // counter wrap: 255 frames, then the 256th returns it to 0
      do_reset();
      for (int k = 0; k < 255; k++) send_word(8'(k));
      wait_idle();
      chk("wrap_255", fr1, 8'd255);
      send_word(8'hC5);
      wait_idle();
      chk("wrap_0_msb", fr1, 8'd0);
      chk("wrap_0_lsb", fr0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
